// File: rtl/arb_defs.sv
// Shared constants, state encodings and helpers for the 4-way round-robin arbiter.
package arb_defs;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    onehot4 = NUM_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating picker: first unmasked request at or after ptr, mod 4.
module rr_pick4
  import arb_defs::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_ptr,
  input  logic [NUM_REQ-1:0] i_mask,
  output logic               o_found,
  output logic [SEL_W-1:0]   o_idx
);
  logic [NUM_REQ-1:0]   w_eff;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SEL_W-1:0]     w_enc;

  always_comb begin
    w_eff = i_req & ~i_mask;
    // Doubling the vector turns the rotate into a plain shift.
    w_dbl = {w_eff, w_eff} >> i_ptr;
    w_rot = w_dbl[NUM_REQ-1:0];
    w_enc = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (w_rot[i]) w_enc = SEL_W'(i);
    o_idx   = w_enc + i_ptr;
    o_found = |w_eff;
  end
endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for one shared resource port with completion handshake
// and watchdog abort of hung grants.
module rr_arbiter4
  import arb_defs::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_res_done,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_res_start,
  output logic               o_busy,
  output logic               o_timeout_err,
  output logic [SEL_W-1:0]   o_timeout_id
);
  localparam int CNT_W = $clog2(MAX_WAIT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(MAX_WAIT - 1);

  logic [0:0]         r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [SEL_W-1:0]   r_sel;
  logic               r_res_start;
  logic               r_busy;
  logic               r_terr;
  logic [SEL_W-1:0]   r_tid;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_granting;
  logic               w_done;
  logic               w_term;
  logic               w_release;
  logic [SEL_W-1:0]   w_ptr;
  logic [NUM_REQ-1:0] w_mask;
  logic               w_found;
  logic [SEL_W-1:0]   w_idx;

  always_comb begin
    w_granting = (r_state == ST_GRANT);
    w_done     = w_granting && i_res_done;
    w_term     = w_granting && (r_cnt == TERM);
    w_release  = w_done || w_term;
    // On release the finisher is masked and the search starts just past it.
    w_ptr  = w_granting ? r_sel + 1'b1 : r_ptr;
    w_mask = w_granting ? onehot4(r_sel) : '0;
  end

  rr_pick4 u_pick (
    .i_req  (i_req),
    .i_ptr  (w_ptr),
    .i_mask (w_mask),
    .o_found(w_found),
    .o_idx  (w_idx)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_sel       <= '0;
      r_res_start <= 1'b0;
      r_busy      <= 1'b0;
      r_terr      <= 1'b0;
      r_tid       <= '0;
      r_cnt       <= '0;
    end else begin
      r_res_start <= 1'b0;
      r_terr      <= 1'b0;
      if (!w_granting || w_release) begin
        if (w_release) begin
          r_ptr <= r_sel + 1'b1;
          if (!w_done) begin
            r_terr <= 1'b1;
            r_tid  <= r_sel;
          end
        end
        if (w_found) begin
          r_state     <= ST_GRANT;
          r_gnt       <= onehot4(w_idx);
          r_sel       <= w_idx;
          r_res_start <= 1'b1;
          r_busy      <= 1'b1;
          r_cnt       <= '0;
        end else begin
          // sel deliberately holds so the mux output stays put while idle.
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_gnt         = r_gnt;
  assign o_sel         = r_sel;
  assign o_res_start   = r_res_start;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_terr;
  assign o_timeout_id  = r_tid;
endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Round-robin arbiter that shares one BUS_WIDTH-wide resource port, such as the memory or register-file write port, among four requesters. It sequences the 4:1 selection datapath by driving its 2-bit selector, holds each grant until the resource reports completion, and recovers from a hung transaction with a watchdog timeout. It sits between the requesting units and the shared resource, and its `sel` output feeds the mux4 selector directly.

## Interface
- `MAX_WAIT`, default 64: the maximum number of cycles a grant may wait for `res_done` before it is aborted. Legal range is 2..1023.
- `clk` input 1: the single clock. All logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 4: level request, one bit per requester. A requester holds its bit high until it sees `res_done` while granted.
- `res_done` input 1: single-cycle pulse from the resource marking completion of the granted transaction.
- `gnt` output 4: one-hot grant, or all zero when no requester is granted.
- `sel` output 2: binary index of the granted requester, driven to the mux4 selector.
- `res_start` output 1: single-cycle strobe in the first cycle of each grant.
- `busy` output 1: high while any grant is active.
- `timeout_err` output 1: single-cycle pulse when a grant is aborted by the watchdog.
- `timeout_id` output 2: index of the aborted requester. It is valid while `timeout_err` is high and holds its value afterwards.

## Operation
- The FSM has two states, IDLE and GRANT.
- The priority pointer `ptr` (2 bits) names the highest-priority requester. The search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- **IDLE, no request:** `gnt`=0, `busy`=0, and `sel` holds its last value.
- **IDLE, any `req` bit high:** pick the first set bit in search order. Next cycle: state=GRANT, `gnt`=onehot(idx), `sel`=idx, `res_start`=1, `busy`=1, watchdog counter=0.
- **GRANT, each cycle without `res_done`:**
  - The watchdog counter increments.
  - `gnt` and `sel` hold, even if the granted `req` bit drops.
  - Changes on other `req` bits are ignored.
- **GRANT, `res_done`=1 (completion):**
  - `ptr` <= idx+1 mod 4.
  - Re-arbitrate in the same cycle using the new pointer. The finishing requester is masked out of this arbitration.
  - If another request wins, the next cycle starts a new grant (GRANT→GRANT, `res_start`=1, counter=0), giving back-to-back service with no bubble.
  - Otherwise the FSM returns to IDLE, with `gnt`=0 and `busy`=0.
- **GRANT, counter reaches MAX_WAIT-1 without `res_done` (timeout):**
  - Handled as a completion: same pointer update, masking and re-arbitration.
  - Additionally, next cycle: `timeout_err`=1 and `timeout_id`=idx.
- **Simultaneous `res_done` and terminal count:** completion wins and no error is flagged.
- **`res_done` while IDLE:** ignored.
- **Fairness:** every requester holding `req` is granted within 3 other grants.
- **Reset values:** state=IDLE, `ptr`=0, `gnt`=0, `sel`=0, `res_start`=0, `busy`=0, `timeout_err`=0, `timeout_id`=0, counter=0.
- **Reset mid-grant:** the grant is dropped the following cycle with no `timeout_err`. The resource must be reset alongside the arbiter.
- **Counter width:** clog2(MAX_WAIT). The counter never wraps because the terminal count forces release.

## Timing
- **Request to grant:** `req` high at edge t while IDLE gives `gnt`/`sel`/`res_start` at t+1. This is a 1-cycle latency, and all outputs are registered.
- **Completion:** `res_done` at cycle d causes `gnt` to change (next grant or zero) at d+1.
- **Bus occupancy:** the minimum grant length is 1 cycle, when `res_done` arrives in the `res_start` cycle.
- **Timeout:** a grant that starts at cycle s with no `res_done` has its last granted cycle at s+MAX_WAIT-1. `timeout_err` pulses at s+MAX_WAIT.
- **Selector stability:** `sel` changes only on the edge where `gnt` changes, so the mux4 output is stable for the entire grant.

## Structure
- Shared package/include file `arb_defs` holds:
  - `NUM_REQ`=4 and `SEL_W`=2.
  - The state encodings `ST_IDLE`=1'b0 and `ST_GRANT`=1'b1.
- Sub-module `rr_pick4` is a combinational picker:
  - Inputs: `req[3:0]`, `ptr[1:0]`, `mask[3:0]`.
  - Outputs: `found`, `idx[1:0]`.
  - It rotates, applies a fixed-priority encode, then un-rotates. The arbiter instantiates it once.
- The rest of `rr_arbiter4` is the FSM, the pointer, the watchdog counter and the output registers.

## Test plan
- **Single request:** after reset, `req`=0001 at cycle 1, `res_done` at cycle 4 → `gnt`=0001, `sel`=0 and `res_start` at cycle 2; `gnt`=0000 and `busy`=0 at cycle 5.
- **Contention and rotation:** all four `req` held high, `res_done` every 2nd cycle → grant order 0,1,2,3,0 with no idle cycle between grants, and `res_start` pulses exactly once per grant.
- **Masking:** only `req[2]` held high through its `res_done` → the FSM returns to IDLE for one cycle and then re-grants 2. Requester 2 is never granted back-to-back with itself.
- **Timeout:** `MAX_WAIT`=8, `req`=0100, no `res_done` → `gnt` high for 8 cycles, then `timeout_err`=1 with `timeout_id`=2 for one cycle and `gnt`=0.
- **Done at terminal count:** `MAX_WAIT`=8 with `res_done` in the 8th granted cycle → normal release and `timeout_err` stays 0.
- **Reset mid-grant:** `rst` asserted during GRANT with `req`=1000 → next cycle all outputs are at reset values. After `rst` drops, `req` 1000 is granted with `ptr`=0 priority.
